// File: rtl/memtest_pkg.sv
// Shared types and bit maps for the SRAM memtest engine: FSM states,
// SPI control/status bit indices, phase codes and test patterns.
package memtest_pkg;

  localparam int unsigned CTRL_W   = 16;
  localparam int unsigned STATUS_W = 16;

  // Control bit-vector map
  localparam int unsigned START       = 0;
  localparam int unsigned PAT_LO      = 1;
  localparam int unsigned PAT_HI      = 2;
  localparam int unsigned STOP_ON_ERR = 3;
  localparam int unsigned INJECT      = 4;
  localparam int unsigned ABORT       = 7;

  // Status bit-vector map
  localparam int unsigned ST_BUSY   = 0;
  localparam int unsigned ST_DONE   = 1;
  localparam int unsigned ST_FAIL   = 2;
  localparam int unsigned ST_PH_LO  = 3;
  localparam int unsigned ST_PH_HI  = 4;
  localparam int unsigned ST_CNT_LO = 8;
  localparam int unsigned ST_CNT_HI = 15;

  typedef enum logic [2:0] {
    IDLE,
    WR_SETUP,
    WR_PULSE,
    WR_HOLD,
    RD_SETUP,
    RD_WAIT,
    RD_CHECK,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    PH_IDLE  = 2'd0,
    PH_WRITE = 2'd1,
    PH_READ  = 2'd2,
    PH_DONE  = 2'd3
  } phase_t;

  typedef enum logic [1:0] {
    PAT_ZERO  = 2'd0,
    PAT_ONES  = 2'd1,
    PAT_ADDR  = 2'd2,
    PAT_NADDR = 2'd3
  } pattern_t;

  // Byte written to / expected from an address under a given pattern
  function automatic logic [7:0] pattern_byte(input pattern_t pat, input logic [7:0] a);
    logic [7:0] b;
    b = 8'h00;
    case (pat)
      PAT_ZERO:  b = 8'h00;
      PAT_ONES:  b = 8'hFF;
      PAT_ADDR:  b = a;
      PAT_NADDR: b = ~a;
      default:   b = 8'h00;
    endcase
    return b;
  endfunction

  function automatic phase_t phase_of(input state_t s);
    phase_t ph;
    case (s)
      IDLE:                        ph = PH_IDLE;
      WR_SETUP, WR_PULSE, WR_HOLD: ph = PH_WRITE;
      RD_SETUP, RD_WAIT, RD_CHECK: ph = PH_READ;
      default:                     ph = PH_DONE;
    endcase
    return ph;
  endfunction

endpackage

// File: rtl/memtest_engine_if.sv
// Asynchronous 8-bit SRAM bus between the memtest engine (master) and the
// memory device (slave).
interface memtest_engine_if #(
  parameter int unsigned ADDR_W = 17,
  parameter int unsigned DATA_W = 8
);
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_dq_o;
  logic [DATA_W-1:0] sram_dq_i;
  logic              sram_dq_oe;
  logic              sram_ce_n;
  logic              sram_we_n;
  logic              sram_oe_n;

  modport master (
    output sram_addr, sram_dq_o, sram_dq_oe, sram_ce_n, sram_we_n, sram_oe_n,
    input  sram_dq_i
  );

  modport slave (
    input  sram_addr, sram_dq_o, sram_dq_oe, sram_ce_n, sram_we_n, sram_oe_n,
    output sram_dq_i
  );
endinterface

// File: rtl/memtest_engine_sync_2ff.sv
// Parameterized-width two-flop synchronizer, asynchronously reset to zero.
module sync_2ff #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/memtest_engine.sv
// SRAM write-then-read-compare engine driven from SPI control bits.
// Optional compare-path self-test (inverted bit 0 at address 0): MEMTEST_INJECT_EN.
module memtest_engine
  import memtest_pkg::*;
#(
  parameter int unsigned ADDR_W      = 17,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic                input_clk,
  input  logic                reset,
  input  logic [CTRL_W-1:0]   ctrl_bits,
  output logic [STATUS_W-1:0] status_bits,
  memtest_engine_if.master    sram
);
  localparam int unsigned WAIT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(WAIT_CYCLES - 1);

  logic [CTRL_W-1:0]   ctrl_s;
  logic                start_d;
  logic                start_edge;
  logic                abort;
  pattern_t            ctrl_pat;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   addr, addr_nxt;
  logic [DATA_W-1:0]   dq_o, dq_o_nxt;
  logic [DATA_W-1:0]   rd_data, rd_data_nxt;
  logic                dq_oe, dq_oe_nxt;
  logic                ce_n, ce_n_nxt;
  logic                we_n, we_n_nxt;
  logic                oe_n, oe_n_nxt;
  logic [WAIT_W-1:0]   wait_cnt, wait_cnt_nxt;
  pattern_t            pat, pat_nxt;
  logic                stop_err, stop_err_nxt;
  logic [STATUS_W-1:0] status, status_nxt;
  logic [7:0]          err_cnt;
  logic [DATA_W-1:0]   expected;
  logic                mismatch;
  logic                last;
  logic                unused_ctrl;
`ifdef MEMTEST_INJECT_EN
  logic                inject, inject_nxt;
`endif

  function automatic logic [DATA_W-1:0] pat_data(input pattern_t p, input logic [ADDR_W-1:0] a);
    return DATA_W'(pattern_byte(p, 8'(a)));
  endfunction

  sync_2ff #(.W(CTRL_W)) u_sync (
    .clk (input_clk),
    .rst (reset),
    .d   (ctrl_bits),
    .q   (ctrl_s)
  );

  always_ff @(posedge input_clk or posedge reset) begin
    if (reset) start_d <= 1'b0;
    else       start_d <= ctrl_s[START];
  end

  assign start_edge = ctrl_s[START] & ~start_d;
  assign abort      = ctrl_s[ABORT];
  assign ctrl_pat   = pattern_t'(ctrl_s[PAT_HI:PAT_LO]);
  assign err_cnt    = status[ST_CNT_HI:ST_CNT_LO];
  assign last       = &addr;

`ifdef MEMTEST_INJECT_EN
  assign unused_ctrl = ^{ctrl_s[15:8], ctrl_s[6:5]};
`else
  assign unused_ctrl = ^{ctrl_s[15:8], ctrl_s[6:5], ctrl_s[INJECT]};
`endif

  // Expected read-back for the current address
  always_comb begin
    expected = pat_data(pat, addr);
`ifdef MEMTEST_INJECT_EN
    if (inject && (addr == '0)) expected[0] = ~expected[0];
`endif
  end

  assign mismatch = (rd_data != expected);

  // Next-state and next-output logic; every SRAM strobe leaves a flop
  always_comb begin
    state_nxt    = state;
    addr_nxt     = addr;
    dq_o_nxt     = dq_o;
    dq_oe_nxt    = dq_oe;
    ce_n_nxt     = ce_n;
    we_n_nxt     = we_n;
    oe_n_nxt     = oe_n;
    wait_cnt_nxt = wait_cnt;
    rd_data_nxt  = rd_data;
    pat_nxt      = pat;
    stop_err_nxt = stop_err;
    status_nxt   = status;
`ifdef MEMTEST_INJECT_EN
    inject_nxt   = inject;
`endif

    if (abort && (state != IDLE)) begin
      state_nxt           = IDLE;
      dq_oe_nxt           = 1'b0;
      ce_n_nxt            = 1'b1;
      we_n_nxt            = 1'b1;
      oe_n_nxt            = 1'b1;
      status_nxt[ST_BUSY] = 1'b0;
      status_nxt[ST_DONE] = 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start_edge && !abort) begin
            state_nxt                     = WR_SETUP;
            addr_nxt                      = '0;
            dq_o_nxt                      = pat_data(ctrl_pat, ADDR_W'(0));
            dq_oe_nxt                     = 1'b1;
            ce_n_nxt                      = 1'b0;
            pat_nxt                       = ctrl_pat;
            stop_err_nxt                  = ctrl_s[STOP_ON_ERR];
            status_nxt[ST_BUSY]           = 1'b1;
            status_nxt[ST_DONE]           = 1'b0;
            status_nxt[ST_FAIL]           = 1'b0;
            status_nxt[ST_CNT_HI:ST_CNT_LO] = 8'd0;
`ifdef MEMTEST_INJECT_EN
            inject_nxt                    = ctrl_s[INJECT];
`endif
          end
        end
        WR_SETUP: begin
          state_nxt    = WR_PULSE;
          we_n_nxt     = 1'b0;
          wait_cnt_nxt = WAIT_LOAD;
        end
        WR_PULSE: begin
          if (wait_cnt == '0) begin
            state_nxt = WR_HOLD;
            we_n_nxt  = 1'b1;
          end else begin
            wait_cnt_nxt = wait_cnt - WAIT_W'(1);
          end
        end
        WR_HOLD: begin
          if (last) begin
            state_nxt = RD_SETUP;
            addr_nxt  = '0;
            dq_oe_nxt = 1'b0;
            oe_n_nxt  = 1'b0;
          end else begin
            state_nxt = WR_SETUP;
            addr_nxt  = addr + ADDR_W'(1);
            dq_o_nxt  = pat_data(pat, addr + ADDR_W'(1));
          end
        end
        RD_SETUP: begin
          state_nxt    = RD_WAIT;
          wait_cnt_nxt = WAIT_LOAD;
        end
        RD_WAIT: begin
          // Capture read data on the last clock oe_n is still low
          if (wait_cnt == '0) begin
            state_nxt   = RD_CHECK;
            oe_n_nxt    = 1'b1;
            rd_data_nxt = sram.sram_dq_i;
          end else begin
            wait_cnt_nxt = wait_cnt - WAIT_W'(1);
          end
        end
        RD_CHECK: begin
          if (mismatch) begin
            status_nxt[ST_FAIL] = 1'b1;
            if (err_cnt != 8'hFF) status_nxt[ST_CNT_HI:ST_CNT_LO] = err_cnt + 8'd1;
          end
          if ((mismatch && stop_err) || last) begin
            state_nxt           = DONE;
            ce_n_nxt            = 1'b1;
            status_nxt[ST_BUSY] = 1'b0;
            status_nxt[ST_DONE] = 1'b1;
          end else begin
            state_nxt = RD_SETUP;
            addr_nxt  = addr + ADDR_W'(1);
            oe_n_nxt  = 1'b0;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end

    status_nxt[ST_PH_HI:ST_PH_LO] = 2'(phase_of(state_nxt));
  end

  always_ff @(posedge input_clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      addr     <= '0;
      dq_o     <= '0;
      dq_oe    <= 1'b0;
      ce_n     <= 1'b1;
      we_n     <= 1'b1;
      oe_n     <= 1'b1;
      wait_cnt <= '0;
      rd_data  <= '0;
      pat      <= PAT_ZERO;
      stop_err <= 1'b0;
      status   <= '0;
`ifdef MEMTEST_INJECT_EN
      inject   <= 1'b0;
`endif
    end else begin
      state    <= state_nxt;
      addr     <= addr_nxt;
      dq_o     <= dq_o_nxt;
      dq_oe    <= dq_oe_nxt;
      ce_n     <= ce_n_nxt;
      we_n     <= we_n_nxt;
      oe_n     <= oe_n_nxt;
      wait_cnt <= wait_cnt_nxt;
      rd_data  <= rd_data_nxt;
      pat      <= pat_nxt;
      stop_err <= stop_err_nxt;
      status   <= status_nxt;
`ifdef MEMTEST_INJECT_EN
      inject   <= inject_nxt;
`endif
    end
  end

  assign sram.sram_addr  = addr;
  assign sram.sram_dq_o  = dq_o;
  assign sram.sram_dq_oe = dq_oe;
  assign sram.sram_ce_n  = ce_n;
  assign sram.sram_we_n  = we_n;
  assign sram.sram_oe_n  = oe_n;
  assign status_bits     = status;

endmodule

// File: tb/tb_memtest_engine.sv
// Bench for memtest_engine: behavioural SRAM with fault injection, a
// per-test expected-result model, bus-protocol monitors and random tests.
module tb_memtest_engine;
  localparam int unsigned ADDR_W      = 4;
  localparam int unsigned DATA_W      = 8;
  localparam int unsigned WAIT_CYCLES = 2;
  localparam int N_ADDR = 1 << ADDR_W;
  localparam int T_ADDR = WAIT_CYCLES + 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] ctrl_bits;
  logic [15:0] status_bits;

  int n_tests = 0;
  int n_fail  = 0;

  memtest_engine_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) sif ();

  memtest_engine #(
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .WAIT_CYCLES (WAIT_CYCLES)
  ) dut (
    .input_clk   (clk),
    .reset       (reset),
    .ctrl_bits   (ctrl_bits),
    .status_bits (status_bits),
    .sram        (sif)
  );

  always #5 clk = ~clk;

  // Behavioural SRAM: stuck-at-0 mask and one fully corrupted address on reads
  logic [7:0] mem [N_ADDR];
  logic [7:0] stuck_mask = 8'h00;
  int         bad_addr   = -1;

  always @(posedge clk)
    if (!sif.sram_ce_n && !sif.sram_we_n) mem[sif.sram_addr] <= sif.sram_dq_o;

  always_comb begin
    sif.sram_dq_i = 8'h5A;
    if (!sif.sram_ce_n && !sif.sram_oe_n) begin
      sif.sram_dq_i = mem[sif.sram_addr] & ~stuck_mask;
      if (int'(sif.sram_addr) == bad_addr) sif.sram_dq_i = ~mem[sif.sram_addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [7:0] pat_val(input int p, input int a);
    logic [7:0] av;
    av = 8'(a);
    case (p)
      0:       return 8'h00;
      1:       return 8'hFF;
      2:       return av;
      default: return ~av;
    endcase
  endfunction

  // Bus monitors: no drive fight, and write data/address settled before we_n falls
  logic [ADDR_W-1:0] prev_addr = '0;
  logic [7:0]        prev_dq   = 8'h00;
  logic              prev_we_n = 1'b1;

  always @(negedge clk) begin
    if (!reset) begin
      check("bus_contention", 32'(sif.sram_dq_oe & ~sif.sram_oe_n), 32'd0);
      if (prev_we_n && !sif.sram_we_n) begin
        check("we_setup", 32'({sif.sram_addr, sif.sram_dq_o}), 32'({prev_addr, prev_dq}));
        check("we_dq_oe", 32'(sif.sram_dq_oe), 32'd1);
      end
    end
    prev_addr = sif.sram_addr;
    prev_dq   = sif.sram_dq_o;
    prev_we_n = sif.sram_we_n;
  end

  // One full test: model expected errors/latency, run DUT, compare
  task automatic run_test(input int p, input bit stop, input bit inj,
                          input logic [7:0] stuck, input int bad, input string name);
    int         exp_cnt, last, lat;
    bit         seen;
    logic [7:0] e, r;
    logic [15:0] exp_status;

    exp_cnt = 0;
    last    = N_ADDR - 1;
    for (int a = 0; a < N_ADDR; a++) begin
      e = pat_val(p, a);
`ifdef MEMTEST_INJECT_EN
      if (inj && a == 0) e[0] = ~e[0];
`endif
      r = (a == bad) ? ~pat_val(p, a) : (pat_val(p, a) & ~stuck);
      if (r != e) begin
        if (exp_cnt < 255) exp_cnt++;
        if (stop) begin
          last = a;
          break;
        end
      end
    end
    exp_status = {8'(exp_cnt), 3'b000, 2'b11, (exp_cnt != 0), 1'b1, 1'b0};

    stuck_mask = stuck;
    bad_addr   = bad;
    ctrl_bits  = 16'h0000;
    ctrl_bits[2:1] = 2'(p);
    ctrl_bits[3]   = stop;
    ctrl_bits[4]   = inj;
    tick(3);
    ctrl_bits[0] = 1'b1;

    lat  = 0;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick(1);
      lat++;
      if (status_bits[0]) seen = 1'b1;
    end
    check({name, "_busy_seen"}, 32'(seen), 32'd1);
    check({name, "_start_lat"}, 32'(lat <= 4), 32'd1);

    // Toggle start mid-test; the running test must ignore it
    lat  = 0;
    seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      if (i == 40) ctrl_bits[0] = 1'b0;
      if (i == 50) ctrl_bits[0] = 1'b1;
      tick(1);
      lat++;
      if (status_bits[1]) seen = 1'b1;
    end
    check({name, "_done_seen"}, 32'(seen), 32'd1);
    check({name, "_done_lat"}, 32'(lat), 32'((N_ADDR + last + 1) * T_ADDR));
    check({name, "_status"}, 32'(status_bits), 32'(exp_status));
    check({name, "_strobes"}, 32'({sif.sram_ce_n, sif.sram_we_n, sif.sram_oe_n, sif.sram_dq_oe}), 32'(4'b1110));
    for (int a = 0; a < N_ADDR; a++)
      check({name, "_mem"}, 32'(mem[a]), 32'(pat_val(p, a)));

    ctrl_bits[0] = 1'b0;
    tick(4);
  endtask

  initial begin
    int         lat, p, mode, bad;
    bit         seen;
    logic [7:0] cnt, stuck;

    reset     = 1'b1;
    ctrl_bits = 16'h0000;
    tick(2);
    check("reset_status", 32'(status_bits), 32'h0);
    check("reset_strobes", 32'({sif.sram_ce_n, sif.sram_we_n, sif.sram_oe_n, sif.sram_dq_oe}), 32'(4'b1110));
    check("reset_addr_dq", 32'({sif.sram_addr, sif.sram_dq_o}), 32'h0);
    reset = 1'b0;
    tick(3);
    check("idle_status", 32'(status_bits), 32'h0);

    run_test(2, 1'b0, 1'b0, 8'h00, -1, "p2_clean");
    check("p2_clean_lit", 32'(status_bits), 32'h001A);
    run_test(3, 1'b0, 1'b0, 8'h08, -1, "p3_stuck3");
    check("p3_stuck3_lit", 32'(status_bits), 32'h081E);
    run_test(1, 1'b1, 1'b0, 8'h00, 5, "p1_stop5");
    check("p1_stop5_lit", 32'(status_bits), 32'h011E);
    run_test(0, 1'b0, 1'b1, 8'h00, -1, "inject");
`ifdef MEMTEST_INJECT_EN
    check("inject_lit", 32'(status_bits[15:0]), 32'h011E);
`else
    check("inject_lit", 32'(status_bits[15:0]), 32'h001A);
`endif

    for (int t = 0; t < 6; t++) begin
      p     = int'($urandom_range(3, 0));
      mode  = int'($urandom_range(2, 0));
      stuck = (mode == 1) ? 8'(32'd1 << $urandom_range(7, 0)) : 8'h00;
      bad   = (mode == 2) ? int'($urandom_range(N_ADDR - 1, 0)) : -1;
      run_test(p, 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), stuck, bad, "rand");
    end

    // Abort during the read pass, with every read failing
    stuck_mask = 8'h01;
    bad_addr   = -1;
    ctrl_bits  = 16'h0002;
    tick(3);
    ctrl_bits[0] = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      tick(1);
      if (status_bits[4:3] == 2'd2 && status_bits[15:8] >= 8'd3) seen = 1'b1;
    end
    check("abort_reach_read", 32'(seen), 32'd1);
    ctrl_bits[7] = 1'b1;
    lat  = 0;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick(1);
      lat++;
      if (status_bits[1:0] == 2'b00 && status_bits[4:3] == 2'b00) seen = 1'b1;
    end
    check("abort_idle", 32'(seen), 32'd1);
    check("abort_lat", 32'(lat <= 4), 32'd1);
    check("abort_strobes", 32'({sif.sram_ce_n, sif.sram_we_n, sif.sram_oe_n, sif.sram_dq_oe}), 32'(4'b1110));
    check("abort_fail_kept", 32'(status_bits[2]), 32'd1);
    cnt = status_bits[15:8];
    check("abort_cnt_kept", 32'(cnt != 8'd0), 32'd1);
    ctrl_bits[0] = 1'b0;
    tick(3);
    ctrl_bits[0] = 1'b1;
    tick(10);
    check("abort_start_ignored", 32'({status_bits[4:3], status_bits[1:0]}), 32'd0);
    check("abort_cnt_stable", 32'(status_bits[15:8]), 32'(cnt));
    ctrl_bits  = 16'h0000;
    stuck_mask = 8'h00;
    tick(4);

    // Asynchronous reset in the middle of the write pass
    ctrl_bits = 16'h0004;
    tick(3);
    ctrl_bits[0] = 1'b1;
    tick(20);
    check("pre_reset_phase", 32'(status_bits[4:3]), 32'd1);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("midreset_strobes", 32'({sif.sram_ce_n, sif.sram_we_n, sif.sram_oe_n, sif.sram_dq_oe}), 32'(4'b1110));
    check("midreset_status", 32'(status_bits), 32'h0);
    check("midreset_addr_dq", 32'({sif.sram_addr, sif.sram_dq_o}), 32'h0);
    ctrl_bits = 16'h0000;
    tick(2);
    reset = 1'b0;
    tick(4);
    check("post_reset_idle", 32'(status_bits), 32'h0);

    run_test(3, 1'b0, 1'b0, 8'h00, -1, "post_reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
